instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 clock  in  1  sole clock; all state updates on the rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 id_stall  in  1  ID cannot accept a new instruction this cycle; IF/ID register holds.
REQ-005 if_flush  in  1  squash the instruction transferred to IF/ID this cycle.
REQ-006 id_pc_source_sel  in  2  from ID control: 00 PC+4, 01 jump, 10 branch, 11 jump register.
REQ-007 id_jump_address, id_branch_address, id_jr_address  in  32 each  redirect targets for sel 01/10/11.
REQ-008 imem_req  out  1  instruction memory read request.
REQ-009 imem_addr  out  30  word address, equal to pc[31:2].
REQ-010 imem_ack  in  1  read data valid this cycle; completes the request.
REQ-011 imem_rdata  in  32  instruction word, sampled only when imem_ack=1.
REQ-012 id_instruction  out  32  IF/ID instruction register.
REQ-013 id_pc_plus4  out  32  IF/ID PC+4 register.
REQ-014 id_valid  out  1  1 = id_instruction is a real, unsquashed instruction.
REQ-015 if_busy  out  1  state FETCH with imem_ack=0.

Function
REQ-016 FSM states: WAKE, FETCH, HOLD; WAKE -> FETCH unconditionally after one cycle.
REQ-017 FETCH: imem_req=1; imem_addr stays stable until imem_ack.
REQ-018 FETCH, imem_ack=1, id_stall=0: transfer; stay FETCH; the next request addresses the new pc in the following cycle with no idle cycle.
REQ-019 FETCH, imem_ack=1, id_stall=1: imem_rdata is captured in the skid register, and the state goes to HOLD.
REQ-020 HOLD: imem_req=0; when id_stall=0, transfer the skid word and go to FETCH.
REQ-021 Transfer: id_instruction <= word, or 32'h0 if if_flush=1; id_valid <= ~if_flush; id_pc_plus4 <= pc+4; pc <= next_pc.
REQ-022 next_pc = redir_pc if redir_pending=1; otherwise select by id_pc_source_sel: pc+4, jump, branch or jr address.
REQ-023 Bubble: cycle with id_stall=0 and no transfer: id_instruction <= 32'h0, id_valid <= 0, id_pc_plus4 held, pc held.
REQ-024 Redirect capture: bubble cycle with id_pc_source_sel != 00: redir_pc <= selected target, redir_pending <= 1.
REQ-025 redir_pending clears on every transfer; redir_pending=1 takes priority over id_pc_source_sel.
REQ-026 id_stall=1: IF/ID registers, pc and redirect state hold (skid capture per REQ-019 still occurs).
REQ-027 pc+4 arithmetic is 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-028 Branch delay slot is architectural: the instruction after a branch/jump is always delivered, never auto-squashed.

Reset
REQ-029 reset_n=0 immediately sets state WAKE and imem_req=0.
REQ-030 reset_n=0 immediately sets pc=RESET_VECTOR, id_instruction=0, id_pc_plus4=0, id_valid=0.
REQ-031 reset_n=0 immediately sets redir_pending=0, redir_pc=0 and the skid register to 0.
REQ-032 Reset during an outstanding request abandons it; a late imem_ack after reset release is ignored while in WAKE.

Verification
REQ-033 Release reset, imem_ack tied 1 with rdata=addr-derived -> WAKE cycle; req from cycle 2; addrs 0,1,2 words; id_pc_plus4 4,8,12 on consecutive cycles, id_valid=1.
REQ-034 Ack 3 cycles after req -> imem_addr stable 3 cycles; two bubbles (id_instruction=0, id_valid=0) then word; if_busy=1 during wait.
REQ-035 id_stall=1 in ack cycle for 2 cycles -> HOLD, imem_req=0, IF/ID unchanged; on release the held word is delivered and the next imem_addr = old pc+4.
REQ-036 Branch (sel=10, target 32'h40) in ID at pc=0x8 while delay-slot fetch at 0xC waits 2 cycles -> redir_pending set; 0xC word delivered; next imem_addr=30'h10.
REQ-037 if_flush=1 in a transfer cycle -> id_instruction=0, id_valid=0; pc still advances to next_pc.
REQ-038 reset_n low mid-wait, then ack arrives -> req drops same cycle; outputs reset; fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch -- IF stage with a one-word skid buffer and an IF/ID
// pipeline register.
//
// Fetches one instruction word at a time from instruction memory. It issues
// the next request in the cycle after a transfer, so there is no idle cycle
// between fetches. A stall arriving with the memory acknowledge parks the
// word in a skid register. Redirects that ID presents while no word is
// ready to transfer are remembered until the next transfer uses them.
//
// Ports
//   clock              sole clock, rising edge
//   reset_n            asynchronous active-low reset
//   id_stall           ID cannot accept a word; IF/ID, pc and redirect state hold
//   if_flush           squash the word transferred this cycle
//   id_pc_source_sel   00 pc+4, 01 jump, 10 branch, 11 jump register
//   id_jump_address    redirect target for sel 01
//   id_branch_address  redirect target for sel 10
//   id_jr_address      redirect target for sel 11
//   imem_req           instruction memory read request
//   imem_addr          word address (pc[31:2])
//   imem_ack           read data valid; completes the request
//   imem_rdata         instruction word, sampled only with imem_ack
//   id_instruction     IF/ID instruction register
//   id_pc_plus4        IF/ID pc+4 register
//   id_valid           id_instruction is a real, unsquashed instruction
//   if_busy            fetch outstanding and not acknowledged this cycle
module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        id_stall,
  input  logic        if_flush,
  input  logic [1:0]  id_pc_source_sel,
  input  logic [31:0] id_jump_address,
  input  logic [31:0] id_branch_address,
  input  logic [31:0] id_jr_address,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        if_busy
);

  typedef enum logic [1:0] {
    WAKE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] skid_word;
  logic        redir_pending;
  logic [31:0] redir_pc;
  logic [31:0] sel_target;
  logic [31:0] next_pc;
  logic [31:0] xfer_word;
  logic        xfer;

  // Target chosen by the control word currently in ID.
  function automatic logic [31:0] select_target(
    input logic [1:0]  sel,
    input logic [31:0] seq_pc,
    input logic [31:0] jump_pc,
    input logic [31:0] branch_pc,
    input logic [31:0] jr_pc
  );
    case (sel)
      2'b01:   return jump_pc;
      2'b10:   return branch_pc;
      2'b11:   return jr_pc;
      default: return seq_pc;
    endcase
  endfunction

  // 32-bit modulo increment: 32'hFFFF_FFFC wraps to zero.
  assign pc_plus4   = pc + 32'd4;
  assign sel_target = select_target(id_pc_source_sel, pc_plus4, id_jump_address,
                                    id_branch_address, id_jr_address);
  // A redirect remembered from a bubble cycle outranks whatever ID shows now.
  assign next_pc    = redir_pending ? redir_pc : sel_target;

  assign xfer       = ~id_stall & (((state == FETCH) & imem_ack) | (state == HOLD));
  assign xfer_word  = (state == HOLD) ? skid_word : imem_rdata;

  assign imem_addr  = pc[31:2];
  assign if_busy    = (state == FETCH) & ~imem_ack;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= WAKE;
      imem_req       <= 1'b0;
      pc             <= RESET_VECTOR;
      skid_word      <= 32'h0;
      redir_pending  <= 1'b0;
      redir_pc       <= 32'h0;
      id_instruction <= 32'h0;
      id_pc_plus4    <= 32'h0;
      id_valid       <= 1'b0;
    end else begin
      // Fetch sequencing; imem_req is registered and mirrors "next state is FETCH".
      case (state)
        WAKE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack && id_stall) begin
            skid_word <= imem_rdata;
            state     <= HOLD;
            imem_req  <= 1'b0;
          end
        end
        HOLD: begin
          if (!id_stall) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= WAKE;
          imem_req <= 1'b0;
        end
      endcase

      // IF/ID boundary: transfer, bubble, or hold under stall.
      if (xfer) begin
        id_instruction <= if_flush ? 32'h0 : xfer_word;
        id_valid       <= ~if_flush;
        id_pc_plus4    <= pc_plus4;
        pc             <= next_pc;
        redir_pending  <= 1'b0;
      end else if (!id_stall) begin
        id_instruction <= 32'h0;
        id_valid       <= 1'b0;
        // ID sees a redirect but no word is moving; keep it for the next transfer.
        if (id_pc_source_sel != 2'b00) begin
          redir_pc      <= sel_target;
          redir_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        id_stall = 1'b0;
  logic        if_flush = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [31:0] jump_a = 32'h0;
  logic [31:0] branch_a = 32'h0;
  logic [31:0] jr_a = 32'h0;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] id_instruction;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        if_busy;

  int checks = 0;
  int passed = 0;

  instruction_fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .id_stall          (id_stall),
    .if_flush          (if_flush),
    .id_pc_source_sel  (sel),
    .id_jump_address   (jump_a),
    .id_branch_address (branch_a),
    .id_jr_address     (jr_a),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ack          (imem_ack),
    .imem_rdata        (imem_rdata),
    .id_instruction    (id_instruction),
    .id_pc_plus4       (id_pc_plus4),
    .id_valid          (id_valid),
    .if_busy           (if_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Address-derived instruction word, distinct for every address.
  function automatic logic [31:0] w_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    id_stall = 1'b0; if_flush = 1'b0; sel = 2'b00;
    jump_a = 32'h0; branch_a = 32'h0; jr_a = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
  endtask

  // Leaves the bench at posedge+1 with reset released: the WAKE cycle.
  task automatic hard_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    #2;
    checks++; if (imem_req !== 1'b0) $display("FAIL reset_req got %0b want 0", imem_req); else passed++;
    checks++; if (imem_addr !== 30'h0) $display("FAIL reset_addr got %h want 0", imem_addr); else passed++;
    checks++; if (id_instruction !== 32'h0) $display("FAIL reset_inst got %h want 0", id_instruction); else passed++;
    checks++; if (id_pc_plus4 !== 32'h0) $display("FAIL reset_p4 got %h want 0", id_pc_plus4); else passed++;
    checks++; if (id_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", id_valid); else passed++;
    checks++; if (if_busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", if_busy); else passed++;
  endtask

  task automatic test_boot_stream();
    hard_reset();
    imem_ack = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) $display("FAIL boot_wake_req got %0b want 0", imem_req); else passed++;
    tick();
    checks++; if (id_valid !== 1'b0) $display("FAIL boot_wake_valid got %0b want 0", id_valid); else passed++;
    for (int k = 0; k < 3; k++) begin
      imem_rdata = w_of(32'(4 * k));
      #1;
      checks++; if (imem_req !== 1'b1) $display("FAIL boot_req[%0d] got %0b want 1", k, imem_req); else passed++;
      checks++; if (imem_addr !== 30'(k)) $display("FAIL boot_addr[%0d] got %h want %h", k, imem_addr, 30'(k)); else passed++;
      tick();
      checks++; if (id_instruction !== w_of(32'(4 * k))) $display("FAIL boot_inst[%0d] got %h want %h", k, id_instruction, w_of(32'(4 * k))); else passed++;
      checks++; if (id_pc_plus4 !== 32'(4 * k + 4)) $display("FAIL boot_p4[%0d] got %h want %h", k, id_pc_plus4, 32'(4 * k + 4)); else passed++;
      checks++; if (id_valid !== 1'b1) $display("FAIL boot_valid[%0d] got %0b want 1", k, id_valid); else passed++;
    end
  endtask

  task automatic test_wait_and_stall();
    hard_reset();
    tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (imem_addr !== 30'h0) $display("FAIL wait_addr[%0d] got %h want 0", k, imem_addr); else passed++;
      checks++; if (if_busy !== 1'b1) $display("FAIL wait_busy[%0d] got %0b want 1", k, if_busy); else passed++;
      tick();
      checks++; if (id_instruction !== 32'h0) $display("FAIL wait_inst[%0d] got %h want 0", k, id_instruction); else passed++;
      checks++; if (id_valid !== 1'b0) $display("FAIL wait_valid[%0d] got %0b want 0", k, id_valid); else passed++;
    end
    imem_ack = 1'b1; imem_rdata = w_of(32'h0);
    #1;
    checks++; if (imem_addr !== 30'h0) $display("FAIL wait_addr_ack got %h want 0", imem_addr); else passed++;
    checks++; if (if_busy !== 1'b0) $display("FAIL wait_busy_ack got %0b want 0", if_busy); else passed++;
    tick();
    checks++; if (id_instruction !== w_of(32'h0)) $display("FAIL wait_inst_ack got %h want %h", id_instruction, w_of(32'h0)); else passed++;
    checks++; if (id_pc_plus4 !== 32'h4) $display("FAIL wait_p4_ack got %h want 4", id_pc_plus4); else passed++;
    // Stall arrives with the acknowledge and lasts two cycles.
    imem_rdata = w_of(32'h4); id_stall = 1'b1;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 2; k++) begin
      checks++; if (imem_req !== 1'b0) $display("FAIL hold_req[%0d] got %0b want 0", k, imem_req); else passed++;
      checks++; if (id_instruction !== w_of(32'h0)) $display("FAIL hold_inst[%0d] got %h want %h", k, id_instruction, w_of(32'h0)); else passed++;
      checks++; if (id_pc_plus4 !== 32'h4) $display("FAIL hold_p4[%0d] got %h want 4", k, id_pc_plus4); else passed++;
      if (k == 0) tick();
    end
    id_stall = 1'b0;
    tick();
    checks++; if (id_instruction !== w_of(32'h4)) $display("FAIL hold_release_inst got %h want %h", id_instruction, w_of(32'h4)); else passed++;
    checks++; if (id_pc_plus4 !== 32'h8) $display("FAIL hold_release_p4 got %h want 8", id_pc_plus4); else passed++;
    checks++; if (imem_req !== 1'b1) $display("FAIL hold_release_req got %0b want 1", imem_req); else passed++;
    checks++; if (imem_addr !== 30'h2) $display("FAIL hold_release_addr got %h want 2", imem_addr); else passed++;
  endtask

  task automatic test_branch_flush_wrap_reset();
    hard_reset();
    imem_ack = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      imem_rdata = w_of(32'(4 * k));
      tick();
    end
    // Branch now in ID; delay-slot fetch at 0xC waits two cycles.
    imem_ack = 1'b0; sel = 2'b10; branch_a = 32'h40; jump_a = 32'h100; jr_a = 32'h200;
    tick();
    checks++; if (id_valid !== 1'b0) $display("FAIL br_bubble_valid got %0b want 0", id_valid); else passed++;
    sel = 2'b00;
    tick();
    checks++; if (imem_addr !== 30'h3) $display("FAIL br_wait_addr got %h want 3", imem_addr); else passed++;
    imem_ack = 1'b1; imem_rdata = w_of(32'hC);
    tick();
    checks++; if (id_instruction !== w_of(32'hC)) $display("FAIL br_slot_inst got %h want %h", id_instruction, w_of(32'hC)); else passed++;
    checks++; if (id_valid !== 1'b1) $display("FAIL br_slot_valid got %0b want 1", id_valid); else passed++;
    checks++; if (id_pc_plus4 !== 32'h10) $display("FAIL br_slot_p4 got %h want 10", id_pc_plus4); else passed++;
    checks++; if (imem_addr !== 30'h10) $display("FAIL br_target_addr got %h want 10", imem_addr); else passed++;
    // Flush on a transfer.
    if_flush = 1'b1; imem_rdata = w_of(32'h40);
    tick();
    if_flush = 1'b0;
    checks++; if (id_instruction !== 32'h0) $display("FAIL flush_inst got %h want 0", id_instruction); else passed++;
    checks++; if (id_valid !== 1'b0) $display("FAIL flush_valid got %0b want 0", id_valid); else passed++;
    checks++; if (id_pc_plus4 !== 32'h44) $display("FAIL flush_p4 got %h want 44", id_pc_plus4); else passed++;
    checks++; if (imem_addr !== 30'h11) $display("FAIL flush_addr got %h want 11", imem_addr); else passed++;
    // Jump register to the top word, then wrap.
    sel = 2'b11; jr_a = 32'hFFFF_FFFC; imem_rdata = w_of(32'h44);
    tick();
    checks++; if (imem_addr !== 30'h3FFF_FFFF) $display("FAIL jr_addr got %h want 3fffffff", imem_addr); else passed++;
    sel = 2'b00; imem_rdata = w_of(32'hFFFF_FFFC);
    tick();
    checks++; if (id_pc_plus4 !== 32'h0) $display("FAIL wrap_p4 got %h want 0", id_pc_plus4); else passed++;
    checks++; if (imem_addr !== 30'h0) $display("FAIL wrap_addr got %h want 0", imem_addr); else passed++;
    imem_rdata = w_of(32'h0);
    tick();
    // Reset in the middle of an outstanding request.
    imem_ack = 1'b0;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) $display("FAIL midrst_req got %0b want 0", imem_req); else passed++;
    checks++; if (id_pc_plus4 !== 32'h0) $display("FAIL midrst_p4 got %h want 0", id_pc_plus4); else passed++;
    checks++; if (imem_addr !== 30'h0) $display("FAIL midrst_addr got %h want 0", imem_addr); else passed++;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) $display("FAIL late_ack_req got %0b want 0", imem_req); else passed++;
    tick();
    checks++; if (id_valid !== 1'b0) $display("FAIL late_ack_valid got %0b want 0", id_valid); else passed++;
    checks++; if (imem_req !== 1'b1) $display("FAIL restart_req got %0b want 1", imem_req); else passed++;
    checks++; if (imem_addr !== 30'h0) $display("FAIL restart_addr got %h want 0", imem_addr); else passed++;
  endtask

  task automatic test_random();
    logic        awake, held, pend, m_req, e_valid;
    logic [31:0] pc, rpc, skid, e_inst, e_p4, tgt, w;
    hard_reset();
    awake = 1'b0; held = 1'b0; pend = 1'b0; pc = 32'h0; rpc = 32'h0; skid = 32'h0;
    e_inst = 32'h0; e_p4 = 32'h0; e_valid = 1'b0;
    for (int i = 0; i < 500; i++) begin
      id_stall   = ($urandom_range(0, 3) == 0);
      if_flush   = ($urandom_range(0, 9) == 0);
      imem_ack   = 1'($urandom_range(0, 1));
      sel        = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      jump_a     = $urandom & 32'hFFFF_FFFC;
      branch_a   = $urandom & 32'hFFFF_FFFC;
      jr_a       = $urandom & 32'hFFFF_FFFC;
      imem_rdata = $urandom;
      #1;
      m_req = awake && !held;
      checks++; if (imem_req !== m_req) $display("FAIL rnd_req[%0d] got %0b want %0b", i, imem_req, m_req); else passed++;
      checks++; if (imem_addr !== pc[31:2]) $display("FAIL rnd_addr[%0d] got %h want %h", i, imem_addr, pc[31:2]); else passed++;
      checks++; if (if_busy !== (m_req && !imem_ack)) $display("FAIL rnd_busy[%0d] got %0b want %0b", i, if_busy, m_req && !imem_ack); else passed++;
      case (sel)
        2'b01:   tgt = jump_a;
        2'b10:   tgt = branch_a;
        2'b11:   tgt = jr_a;
        default: tgt = pc + 32'd4;
      endcase
      if (awake && (held || imem_ack)) begin
        w = held ? skid : imem_rdata;
        if (id_stall) begin
          if (!held) begin held = 1'b1; skid = imem_rdata; end
        end else begin
          e_inst = if_flush ? 32'h0 : w;
          e_valid = !if_flush;
          e_p4 = pc + 32'd4;
          pc = pend ? rpc : tgt;
          pend = 1'b0;
          held = 1'b0;
        end
      end else if (!id_stall) begin
        e_inst = 32'h0;
        e_valid = 1'b0;
        if (sel != 2'b00) begin rpc = tgt; pend = 1'b1; end
      end
      awake = 1'b1;
      tick();
      checks++; if (id_instruction !== e_inst) $display("FAIL rnd_inst[%0d] got %h want %h", i, id_instruction, e_inst); else passed++;
      checks++; if (id_pc_plus4 !== e_p4) $display("FAIL rnd_p4[%0d] got %h want %h", i, id_pc_plus4, e_p4); else passed++;
      checks++; if (id_valid !== e_valid) $display("FAIL rnd_valid[%0d] got %0b want %0b", i, id_valid, e_valid); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_boot_stream();
    test_wait_and_stall();
    test_branch_flush_wrap_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
